// File: rtl/uart_rx_buffered.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_buffered
// Brief    : Oversampling 8N1 UART receiver with majority vote and FIFO.
//            Optional parity bit enabled by macro UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_buffered #(
    parameter int CLKS_PER_BIT = 50,
    parameter int FIFO_AW      = 3,
    parameter int PARITY_ODD   = 0
) (
    input  logic               i_Clock,
    input  logic               i_Rst,
    input  logic               i_RX_Serial,
    output logic               o_RX_DV,
    input  logic               i_RX_Ready,
    output logic [7:0]         o_RX_Byte,
    output logic [FIFO_AW:0]   o_Fifo_Count,
    output logic               o_Frame_Err,
    output logic               o_Overrun,
    output logic               o_Parity_Err
);

    localparam int C_CW    = $clog2(CLKS_PER_BIT);
    localparam int C_DEPTH = 2 ** FIFO_AW;
    localparam logic [C_CW-1:0]    C_SMP_A  = C_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [C_CW-1:0]    C_SMP_B  = C_CW'(CLKS_PER_BIT / 2);
    localparam logic [C_CW-1:0]    C_DECIDE = C_CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [C_CW-1:0]    C_LAST   = C_CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   C_FULL   = (FIFO_AW + 1)'(C_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY  = 3'd3,
`endif
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } state_t;

    logic                sync_meta_q, rx_s_q;
    state_t              state_q, state_d;
    logic [C_CW-1:0]     cnt_q, cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                smp_a_q, smp_a_d, smp_b_q, smp_b_d;
    logic                frame_err_q, overrun_q;
    logic                w_vote, w_decide, w_last;
    logic                w_push, w_frame_err, w_parity_err;

    logic [7:0]          mem_q [C_DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, w_rd_next;
    logic [FIFO_AW:0]    count_q, count_d;
    logic [7:0]          head_q, head_d;
    logic                w_pop, w_full, w_wr_en, w_ovr;

`ifdef UART_RX_PARITY_EN
    logic                parity_bit_q, parity_bit_d, parity_err_q;
    logic                w_par_exp;
    assign w_par_exp = (^shift_q) ^ (PARITY_ODD != 0);
`else
    logic                w_unused_parity;
    assign w_unused_parity = (PARITY_ODD != 0);
`endif

    // Two of three samples around mid-bit decide the bit value
    assign w_vote   = (smp_a_q & smp_b_q) | (smp_a_q & rx_s_q) | (smp_b_q & rx_s_q);
    assign w_decide = (cnt_q == C_DECIDE);
    assign w_last   = (cnt_q == C_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = w_last ? '0 : cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        smp_a_d      = (cnt_q == C_SMP_A) ? rx_s_q : smp_a_q;
        smp_b_d      = (cnt_q == C_SMP_B) ? rx_s_q : smp_b_q;
        w_push       = 1'b0;
        w_frame_err  = 1'b0;
        w_parity_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_decide && w_vote) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (w_last) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_decide) begin
                    shift_d = {w_vote, shift_q[7:1]};
                end
                if (w_last) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_decide) begin
                    parity_bit_d = w_vote;
                end
                if (w_last) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed
                if (w_decide) begin
                    cnt_d = '0;
                    if (w_vote) begin
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (parity_bit_q != w_par_exp) begin
                            w_parity_err = 1'b1;
                        end else begin
                            w_push = 1'b1;
                        end
`else
                        w_push = 1'b1;
`endif
                    end else begin
                        state_d     = ST_WAIT_HI;
                        w_frame_err = 1'b1;
                    end
                end
            end
            ST_WAIT_HI: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            sync_meta_q <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            smp_a_q     <= 1'b1;
            smp_b_q     <= 1'b1;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_meta_q <= i_RX_Serial;
            rx_s_q      <= sync_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            smp_a_q     <= smp_a_d;
            smp_b_q     <= smp_b_d;
            frame_err_q <= w_frame_err;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
            parity_err_q <= w_parity_err;
`endif
        end
    end

    // Receive FIFO, first-word fall-through via a registered head byte
    assign w_pop     = (count_q != '0) && i_RX_Ready;
    assign w_full    = (count_q == C_FULL);
    assign w_wr_en   = w_push && (!w_full || w_pop);
    assign w_ovr     = w_push && w_full && !w_pop;
    assign w_rd_next = rd_ptr_q + FIFO_AW'(1);

    always_comb begin
        wr_ptr_d = w_wr_en ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop ? w_rd_next : rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        case ({w_wr_en, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (w_pop) begin
            if (count_q > (FIFO_AW + 1)'(1)) begin
                head_d = mem_q[w_rd_next];
            end else if (w_wr_en) begin
                head_d = shift_q;
            end
        end else if (w_wr_en && (count_q == '0)) begin
            head_d = shift_q;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            overrun_q <= w_ovr;
        end
    end

    assign o_RX_DV      = (count_q != '0);
    assign o_RX_Byte    = head_q;
    assign o_Fifo_Count = count_q;
    assign o_Frame_Err  = frame_err_q;
    assign o_Overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign o_Parity_Err = parity_err_q;
`else
    assign o_Parity_Err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_rx_buffered
// Brief    : Directed self-checking bench for uart_rx_buffered with a byte scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_buffered;

    localparam int CPB     = 16;
    localparam int AW      = 3;
    localparam bit PAR_ODD = 1'b0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          ready = 1'b0;
    logic          dv;
    logic [7:0]    rbyte;
    logic [AW:0]   cnt;
    logic          ferr, ovr, perr;

    int            n_pass  = 0;
    int            n_total = 0;
    int            n_fail  = 0;
    int            fe_cnt  = 0;
    int            ov_cnt  = 0;
    int            pe_cnt  = 0;
    int            multi   = 0;
    logic [7:0]    sb [$];

    uart_rx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW),
        .PARITY_ODD   (int'(PAR_ODD))
    ) dut (
        .i_Clock      (clk),
        .i_Rst        (rst),
        .i_RX_Serial  (rx),
        .o_RX_DV      (dv),
        .i_RX_Ready   (ready),
        .o_RX_Byte    (rbyte),
        .o_Fifo_Count (cnt),
        .o_Frame_Err  (ferr),
        .o_Overrun    (ovr),
        .o_Parity_Err (perr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            fe_cnt = fe_cnt + int'(ferr);
            ov_cnt = ov_cnt + int'(ovr);
            pe_cnt = pe_cnt + int'(perr);
            if (int'(ferr) + int'(ovr) + int'(perr) > 1) multi = multi + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame; glitch_per selects a bit period whose centre is inverted for one cycle
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input int glitch_per, input logic par_flip);
        logic seq [11];
        int   n;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[i+1] = d[i];
`ifdef UART_RX_PARITY_EN
        seq[9]  = (^d) ^ PAR_ODD ^ par_flip;
        seq[10] = stop_bit;
        n = 11;
`else
        seq[9]  = stop_bit ^ (par_flip & 1'b0);
        seq[10] = 1'b1;
        n = 10;
`endif
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < CPB; c++) begin
                rx = (i == glitch_per && c == 9) ? ~seq[i] : seq[i];
                @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int nbits);
        rx = 1'b1;
        repeat (nbits * CPB) @(negedge clk);
    endtask

    task automatic expect_byte(input string tag);
        logic       ok;
        logic [7:0] exp;
        ok = 1'b0;
        for (int i = 0; i < 20 * CPB && !ok; i++) begin
            if (dv) ok = 1'b1;
            else @(negedge clk);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        if (!ok) begin
            check({tag, "_dv_timeout"}, 32'd0, 32'd1);
        end else begin
            check(tag, {24'd0, rbyte}, {24'd0, exp});
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
        end
    endtask

    initial begin
        int fe0, ov0, pe0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dv",    {31'd0, dv},   32'd0);
        check("rst_byte",  {24'd0, rbyte}, 32'd0);
        check("rst_count", {28'd0, cnt},  32'd0);
        check("rst_errs",  {29'd0, ferr, ovr, perr}, 32'd0);
        idle_bits(2);

        // Single byte, held until consumer accepts it
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        sb.push_back(8'hA5);
        idle_bits(1);
        check("t1_count", {28'd0, cnt}, 32'd1);
        check("t1_dv",    {31'd0, dv},  32'd1);
        expect_byte("t1_byte");
        check("t1_dv_after_pop",    {31'd0, dv},  32'd0);
        check("t1_count_after_pop", {28'd0, cnt}, 32'd0);

        // Back-to-back frames overflow the 8-deep FIFO by one
        ov0 = ov_cnt;
        for (int b = 0; b <= 8; b++) begin
            send_frame(8'(b), 1'b1, -1, 1'b0);
            if (b < 8) sb.push_back(8'(b));
        end
        idle_bits(2);
        check("t2_count_full", {28'd0, cnt}, 32'd8);
        check("t2_overrun",    32'(ov_cnt - ov0), 32'd1);
        for (int b = 0; b < 8; b++) expect_byte("t2_drain");
        check("t2_count_empty", {28'd0, cnt}, 32'd0);

        // Short start glitch, then a frame with a mid-bit glitch
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle_bits(2);
        check("t3_glitch_count", {28'd0, cnt}, 32'd0);
        check("t3_glitch_ferr",  32'(fe_cnt - fe0), 32'd0);
        send_frame(8'h3C, 1'b1, 4, 1'b0);
        sb.push_back(8'h3C);
        expect_byte("t3_byte");

        // Framing error followed by a break, then recovery
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, -1, 1'b0);
        rx = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        check("t4_ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("t4_count",       {28'd0, cnt}, 32'd0);
        idle_bits(2);
        check("t4_ferr_after",  32'(fe_cnt - fe0), 32'd1);
        send_frame(8'h12, 1'b1, -1, 1'b0);
        sb.push_back(8'h12);
        expect_byte("t4_byte");

        // Reset in the middle of bit 4 abandons the frame
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 8'h77 >> i;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_dv",    {31'd0, dv},    32'd0);
        check("t5_byte",  {24'd0, rbyte}, 32'd0);
        check("t5_count", {28'd0, cnt},   32'd0);
        idle_bits(2);
        send_frame(8'h81, 1'b1, -1, 1'b0);
        sb.push_back(8'h81);
        idle_bits(1);
        check("t5_count_one", {28'd0, cnt}, 32'd1);
        expect_byte("t5_byte81");
        check("t5_count_end", {28'd0, cnt}, 32'd0);

`ifdef UART_RX_PARITY_EN
        pe0 = pe_cnt;
        send_frame(8'h03, 1'b1, -1, 1'b0);
        sb.push_back(8'h03);
        expect_byte("t6_good_parity");
        send_frame(8'h03, 1'b1, -1, 1'b1);
        idle_bits(1);
        check("t6_perr_pulse", 32'(pe_cnt - pe0), 32'd1);
        check("t6_count",      {28'd0, cnt}, 32'd0);
`else
        pe0 = pe_cnt;
        check("perr_tied_low", 32'(pe_cnt - pe0) + {31'd0, perr}, 32'd0);
`endif

        check("errs_exclusive", 32'(multi), 32'd0);
        check("sb_empty",       32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
